l1_repl_ctrl: RTL and testbench



---
 rtl/l1_repl_ctrl_if.sv | 29 ++
 rtl/l1_repl_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_l1_repl_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_repl_ctrl_if.sv
// Lookup request / response bundle between the tag pipeline and the L1
// replacement controller. The tag side is the master, the controller the slave.
interface l1_repl_ctrl_if #(
  parameter int WAY_NUM   = 4,
  parameter int IDX_WIDTH = 6
);
  logic                 lkp_val;
  logic                 lkp_rdy;
  logic [IDX_WIDTH-1:0] lkp_idx;
  logic [WAY_NUM-1:0]   lkp_tag_cmp;
  logic [WAY_NUM-1:0]   lkp_ld_val;
  logic [WAY_NUM-1:0]   lkp_lock;
  logic                 rsp_val;
  logic                 rsp_hit;
  logic                 rsp_evict;
  logic                 rsp_nvict;
  logic                 rsp_err;
  logic [WAY_NUM-1:0]   rsp_way;

  modport master (
    output lkp_val, lkp_idx, lkp_tag_cmp, lkp_ld_val, lkp_lock,
    input  lkp_rdy, rsp_val, rsp_hit, rsp_evict, rsp_nvict, rsp_err, rsp_way
  );

  modport slave (
    input  lkp_val, lkp_idx, lkp_tag_cmp, lkp_ld_val, lkp_lock,
    output lkp_rdy, rsp_val, rsp_hit, rsp_evict, rsp_nvict, rsp_err, rsp_way
  );
endinterface

// File: rtl/l1_repl_ctrl.sv
// L1 replacement controller: per-set hit/victim way selection with either
// MRU-bit (POLICY=0) or tree-PLRU (POLICY=1) state, way locking, multi-hit
// flagging, a registered response and a sequential state-clear engine.
module l1_repl_ctrl #(
  parameter int WAY_NUM   = 4,
  parameter int IDX_WIDTH = 6,
  parameter int POLICY    = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         init_req,
  output logic         busy,
  l1_repl_ctrl_if.slave bus
);
  localparam int SET_NUM = 2 ** IDX_WIDTH;
  localparam int ST_W    = (POLICY == 1) ? WAY_NUM - 1 : WAY_NUM;
  localparam int LVL     = $clog2(WAY_NUM);

  typedef enum logic {ST_IDLE, ST_INIT} fsm_t;

  fsm_t                 fsm_q, fsm_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;

  logic [ST_W-1:0]    repl_st [SET_NUM];
  logic [ST_W-1:0]    cur_st, upd_st;
  logic [WAY_NUM-1:0] hit_vect, hit_way, free_vect, free_way, avail, pol_way, sel_way;
  logic               accept, any_hit, multi_hit, any_free, any_avail;
  logic               evict_c, nvict_c, do_upd;

  logic               vld_p1, hit_p1, evict_p1, nvict_p1, err_p1;
  logic [WAY_NUM-1:0] way_p1;

  function automatic logic [WAY_NUM-1:0] lsb_onehot(input logic [WAY_NUM-1:0] v);
    return v & (~v + WAY_NUM'(1));
  endfunction

  function automatic logic [WAY_NUM-1:0] msb_onehot(input logic [WAY_NUM-1:0] v);
    logic [WAY_NUM-1:0] r, s;
    r = '0;
    for (int i = 0; i < WAY_NUM; i++) begin
      s = v >> i;
      if (s[0]) r = WAY_NUM'(1) << i;
    end
    return r;
  endfunction

  // MRU-bit: prefer the highest unlocked way not marked used.
  function automatic logic [WAY_NUM-1:0] mru_victim(input logic [WAY_NUM-1:0] used,
                                                    input logic [WAY_NUM-1:0] av);
    logic [WAY_NUM-1:0] cand;
    cand = av & ~used;
    return (|cand) ? msb_onehot(cand) : msb_onehot(av);
  endfunction

  // Once every way is marked used, only the just-touched way stays marked.
  function automatic logic [WAY_NUM-1:0] mru_touch(input logic [WAY_NUM-1:0] used,
                                                   input logic [WAY_NUM-1:0] way);
    logic [WAY_NUM-1:0] upd;
    upd = used | way;
    return (&upd) ? way : upd;
  endfunction

  // Walk the tree from the root; a fully locked half is never entered.
  function automatic logic [WAY_NUM-1:0] plru_victim(input logic [WAY_NUM-2:0] tree,
                                                     input logic [WAY_NUM-1:0] av);
    logic [WAY_NUM-1:0] lo_mask;
    logic [WAY_NUM-2:0] t;
    logic               go_hi, lo_any, hi_any;
    int                 node, lo, span, half;
    node = 0;
    lo   = 0;
    span = WAY_NUM;
    for (int l = 0; l < LVL; l++) begin
      half    = span / 2;
      lo_mask = ((WAY_NUM'(1) << half) - WAY_NUM'(1)) << lo;
      lo_any  = |(av & lo_mask);
      hi_any  = |(av & (lo_mask << half));
      t       = tree >> node;
      go_hi   = t[0];
      if (go_hi && !hi_any)      go_hi = 1'b0;
      else if (!go_hi && !lo_any) go_hi = 1'b1;
      if (go_hi) begin
        lo   = lo + half;
        node = 2 * node + 2;
      end else begin
        node = 2 * node + 1;
      end
      span = half;
    end
    return WAY_NUM'(1) << lo;
  endfunction

  // Every node on the path to the accessed way is pointed at the other half.
  function automatic logic [WAY_NUM-2:0] plru_touch(input logic [WAY_NUM-2:0] tree,
                                                    input logic [WAY_NUM-1:0] way);
    logic [WAY_NUM-1:0] lo_mask;
    logic [WAY_NUM-2:0] t;
    int                 node, lo, span, half;
    t    = tree;
    node = 0;
    lo   = 0;
    span = WAY_NUM;
    for (int l = 0; l < LVL; l++) begin
      half    = span / 2;
      lo_mask = ((WAY_NUM'(1) << half) - WAY_NUM'(1)) << lo;
      if (|(way & (lo_mask << half))) begin
        t    = t & ~((WAY_NUM-1)'(1) << node);
        lo   = lo + half;
        node = 2 * node + 2;
      end else begin
        t    = t | ((WAY_NUM-1)'(1) << node);
        node = 2 * node + 1;
      end
      span = half;
    end
    return t;
  endfunction

  assign busy        = (fsm_q == ST_INIT);
  assign bus.lkp_rdy = ~busy;
  assign accept      = bus.lkp_val & ~busy;
  assign cur_st      = repl_st[bus.lkp_idx];

  assign hit_vect  = bus.lkp_tag_cmp & bus.lkp_ld_val;
  assign hit_way   = lsb_onehot(hit_vect);
  assign any_hit   = |hit_vect;
  assign multi_hit = |(hit_vect & ~hit_way);
  assign avail     = ~bus.lkp_lock;
  assign free_vect = ~bus.lkp_ld_val & avail;
  assign free_way  = lsb_onehot(free_vect);
  assign any_free  = |free_vect;
  assign any_avail = |avail;

  if (POLICY == 1) begin : g_plru
    assign pol_way = plru_victim(cur_st, avail);
    assign upd_st  = plru_touch(cur_st, sel_way);
  end else begin : g_mru
    assign pol_way = mru_victim(cur_st, avail);
    assign upd_st  = mru_touch(cur_st, sel_way);
  end

  // Init engine state register; reset starts a full clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= ST_INIT;
      cnt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
    end
  end

  // Init engine sequencing: sweep every set once, restart on init_req.
  always_comb begin
    fsm_d = fsm_q;
    cnt_d = cnt_q;
    case (fsm_q)
      ST_IDLE: begin
        if (init_req) begin
          fsm_d = ST_INIT;
          cnt_d = '0;
        end
      end
      ST_INIT: begin
        if (init_req) begin
          cnt_d = '0;
        end else if (&cnt_q) begin
          fsm_d = ST_IDLE;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + IDX_WIDTH'(1);
        end
      end
      default: begin
        fsm_d = ST_INIT;
        cnt_d = '0;
      end
    endcase
  end

  // Way selection: hit first, then a free unlocked way, then the policy victim.
  always_comb begin
    sel_way = '0;
    evict_c = 1'b0;
    nvict_c = 1'b0;
    if (any_hit) begin
      sel_way = hit_way;
    end else if (any_free) begin
      sel_way = free_way;
    end else if (any_avail) begin
      sel_way = pol_way;
      evict_c = 1'b1;
    end else begin
      nvict_c = 1'b1;
    end
  end

  assign do_upd = accept & ~nvict_c;

  // Replacement state: cleared by the init sweep, updated by accepted lookups.
  always_ff @(posedge clk) begin
    if (busy)        repl_st[cnt_q]       <= '0;
    else if (do_upd) repl_st[bus.lkp_idx] <= upd_st;
  end

  // ---- stage p1: registered response, all zero when nothing was accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      hit_p1   <= 1'b0;
      evict_p1 <= 1'b0;
      nvict_p1 <= 1'b0;
      err_p1   <= 1'b0;
      way_p1   <= '0;
    end else begin
      vld_p1   <= accept;
      hit_p1   <= accept & any_hit;
      evict_p1 <= accept & evict_c;
      nvict_p1 <= accept & nvict_c;
      err_p1   <= accept & multi_hit;
      way_p1   <= accept ? sel_way : '0;
    end
  end

  assign bus.rsp_val   = vld_p1;
  assign bus.rsp_hit   = hit_p1;
  assign bus.rsp_evict = evict_p1;
  assign bus.rsp_nvict = nvict_p1;
  assign bus.rsp_err   = err_p1;
  assign bus.rsp_way   = way_p1;
endmodule

// File: tb/tb_l1_repl_ctrl.sv
// Bench for l1_repl_ctrl: one MRU and one PLRU instance fed identical lookups,
// checked against a behavioural model of both policies.
module tb_l1_repl_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_req = 1'b0;
  logic busy0, busy1;

  l1_repl_ctrl_if #(.WAY_NUM(4), .IDX_WIDTH(6)) bus0 ();
  l1_repl_ctrl_if #(.WAY_NUM(4), .IDX_WIDTH(6)) bus1 ();

  l1_repl_ctrl #(.WAY_NUM(4), .IDX_WIDTH(6), .POLICY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy0), .bus(bus0));
  l1_repl_ctrl #(.WAY_NUM(4), .IDX_WIDTH(6), .POLICY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .busy(busy1), .bus(bus1));

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hit;
    logic       evict;
    logic       nvict;
    logic       err;
    logic [3:0] way;
  } exp_t;

  int n_tot = 0;
  int n_bad = 0;

  logic [3:0] mru_st  [64];
  logic [2:0] plru_st [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit range_locked(input logic [3:0] lk, input int a, input int b);
    logic [3:0] s;
    for (int i = a; i < b; i++) begin
      s = lk >> i;
      if (!s[0]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int mru_pick(input logic [5:0] idx, input logic [3:0] lk);
    logic [3:0] s;
    for (int i = 3; i >= 0; i--) begin
      s = (lk | mru_st[idx]) >> i;
      if (!s[0]) return i;
    end
    for (int i = 3; i >= 0; i--) begin
      s = lk >> i;
      if (!s[0]) return i;
    end
    return -1;
  endfunction

  function automatic void mru_use(input logic [5:0] idx, input int w);
    logic [3:0] u;
    u = mru_st[idx] | (4'b1 << w);
    if (u == 4'hF) u = 4'b1 << w;
    mru_st[idx] = u;
  endfunction

  function automatic int plru_pick(input logic [5:0] idx, input logic [3:0] lk);
    int lo, hi, n, mid;
    bit up;
    logic [2:0] s;
    lo = 0; hi = 4; n = 0;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      s = plru_st[idx] >> n;
      up = s[0];
      if (up && range_locked(lk, mid, hi))       up = 1'b0;
      else if (!up && range_locked(lk, lo, mid)) up = 1'b1;
      if (up) begin lo = mid; n = 2 * n + 2; end
      else    begin hi = mid; n = 2 * n + 1; end
    end
    return lo;
  endfunction

  function automatic void plru_use(input logic [5:0] idx, input int w);
    int lo, hi, n, mid;
    logic [2:0] t;
    lo = 0; hi = 4; n = 0; t = plru_st[idx];
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (w >= mid) begin t = t & ~(3'b1 << n); lo = mid; n = 2 * n + 2; end
      else          begin t = t | (3'b1 << n);  hi = mid; n = 2 * n + 1; end
    end
    plru_st[idx] = t;
  endfunction

  task automatic model_lkp(input bit pol, input logic [5:0] idx, input logic [3:0] tc,
                           input logic [3:0] ld, input logic [3:0] lk, output exp_t e);
    logic [3:0] hv, s;
    int nh, w;
    e = '0;
    hv = tc & ld;
    nh = $countones(hv);
    w = -1;
    if (nh > 0) begin
      e.hit = 1'b1;
      e.err = (nh > 1);
      for (int i = 3; i >= 0; i--) begin s = hv >> i; if (s[0]) w = i; end
    end else begin
      for (int i = 3; i >= 0; i--) begin s = ld | lk; s = s >> i; if (!s[0]) w = i; end
      if (w < 0) begin
        if (lk != 4'hF) begin
          e.evict = 1'b1;
          w = pol ? plru_pick(idx, lk) : mru_pick(idx, lk);
        end else begin
          e.nvict = 1'b1;
        end
      end
    end
    if (w >= 0) begin
      e.way = 4'b1 << w;
      if (pol) plru_use(idx, w);
      else     mru_use(idx, w);
    end
  endtask

  task automatic drive(input bit v, input int idx, input logic [3:0] tc,
                       input logic [3:0] ld, input logic [3:0] lk);
    bus0.lkp_val = v;  bus0.lkp_idx = 6'(idx);
    bus0.lkp_tag_cmp = tc; bus0.lkp_ld_val = ld; bus0.lkp_lock = lk;
    bus1.lkp_val = v;  bus1.lkp_idx = 6'(idx);
    bus1.lkp_tag_cmp = tc; bus1.lkp_ld_val = ld; bus1.lkp_lock = lk;
  endtask

  // one cycle; called at a negedge while the controllers are idle
  task automatic lookup(input bit v, input int idx, input logic [3:0] tc,
                        input logic [3:0] ld, input logic [3:0] lk);
    exp_t e0, e1;
    e0 = '0;
    e1 = '0;
    drive(v, idx, tc, ld, lk);
    if (v) begin
      model_lkp(1'b0, 6'(idx), tc, ld, lk, e0);
      model_lkp(1'b1, 6'(idx), tc, ld, lk, e1);
    end
    @(posedge clk);
    @(negedge clk);
    bus0.lkp_val = 1'b0;
    bus1.lkp_val = 1'b0;
    chk("rsp_mru", {23'b0, bus0.rsp_val, bus0.rsp_hit, bus0.rsp_evict, bus0.rsp_nvict,
                    bus0.rsp_err, bus0.rsp_way}, {23'b0, v, e0});
    chk("rsp_plru", {23'b0, bus1.rsp_val, bus1.rsp_hit, bus1.rsp_evict, bus1.rsp_nvict,
                     bus1.rsp_err, bus1.rsp_way}, {23'b0, v, e1});
  endtask

  // counts busy negedges with a lookup held pending; called at a negedge
  task automatic count_busy(input string tag);
    int n0, n1, seen_rsp, bad_rdy;
    n0 = 0; n1 = 0; seen_rsp = 0; bad_rdy = 0;
    bus0.lkp_val = 1'b1;
    bus1.lkp_val = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (!busy0 && !busy1) break;
      n0 += int'(busy0);
      n1 += int'(busy1);
      seen_rsp += int'(bus0.rsp_val) + int'(bus1.rsp_val);
      bad_rdy += int'(bus0.lkp_rdy == busy0) + int'(bus1.lkp_rdy == busy1);
      @(negedge clk);
    end
    bus0.lkp_val = 1'b0;
    bus1.lkp_val = 1'b0;
    chk({tag, "_len_mru"}, n0, 64);
    chk({tag, "_len_plru"}, n1, 64);
    chk({tag, "_rsp"}, seen_rsp, 0);
    chk({tag, "_rdy"}, bad_rdy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] mru_seq [5];
    logic [3:0] plru_seq [4];
    int r;
    mru_seq  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    plru_seq = '{4'b0001, 4'b0100, 4'b0010, 4'b1000};
    mru_st  = '{default: '0};
    plru_st = '{default: '0};

    drive(1'b0, 5, 4'h0, 4'hF, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {busy0, busy1}, 2'b11);
    chk("rst_rdy", {bus0.lkp_rdy, bus1.lkp_rdy}, 2'b00);
    chk("rst_rsp", {bus0.rsp_val, bus0.rsp_way, bus1.rsp_val, bus1.rsp_way}, 0);
    rst_n = 1'b1;
    count_busy("boot");

    for (int i = 0; i < 5; i++) begin
      lookup(1'b1, 5, 4'h0, 4'hF, 4'h0);
      chk("mru_seq_way", bus0.rsp_way, mru_seq[i]);
      chk("mru_seq_evict", bus0.rsp_evict, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      lookup(1'b1, 3, 4'h0, 4'hF, 4'h0);
      chk("plru_seq_way", bus1.rsp_way, plru_seq[i]);
    end

    lookup(1'b1, 7, 4'h0, 4'b1011, 4'h0);
    chk("free_way", {bus0.rsp_way, bus1.rsp_way}, {4'b0100, 4'b0100});
    chk("free_evict", {bus0.rsp_evict, bus1.rsp_evict}, 2'b00);
    lookup(1'b1, 7, 4'h0, 4'b1011, 4'b0100);
    chk("lockfree_evict", {bus0.rsp_evict, bus1.rsp_evict}, 2'b11);
    lookup(1'b1, 7, 4'h0, 4'hF, 4'hF);
    chk("nvict", {bus0.rsp_nvict, bus0.rsp_way, bus1.rsp_nvict, bus1.rsp_way}, 10'b1_0000_1_0000);
    lookup(1'b1, 7, 4'h0, 4'hF, 4'h0);
    lookup(1'b1, 7, 4'b0110, 4'hF, 4'h0);
    chk("mhit_way", {bus0.rsp_way, bus1.rsp_way}, {4'b0010, 4'b0010});
    chk("mhit_flags", {bus0.rsp_hit, bus0.rsp_err, bus1.rsp_hit, bus1.rsp_err}, 4'b1111);

    for (int i = 0; i < 500; i++) begin
      logic [3:0] tc, ld, lk;
      bit v;
      v  = ($urandom_range(0, 99) < 85);
      ld = ($urandom_range(0, 99) < 60) ? 4'hF : 4'($urandom_range(0, 15));
      tc = ($urandom_range(0, 99) < 30) ? 4'($urandom_range(0, 15)) : 4'h0;
      lk = ($urandom_range(0, 99) < 50) ? 4'h0 : 4'($urandom_range(0, 15));
      lookup(v, $urandom_range(0, 7), tc, ld, lk);
    end

    init_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;
    repeat (9) @(negedge clk);
    init_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;
    count_busy("reinit");
    mru_st  = '{default: '0};
    plru_st = '{default: '0};
    r = $urandom_range(0, 63);
    lookup(1'b1, r, 4'h0, 4'hF, 4'h0);
    chk("post_init_plru", bus1.rsp_way, 4'b0001);
    chk("post_init_mru", bus0.rsp_way, 4'b1000);

    drive(1'b1, 2, 4'h0, 4'hF, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus0.lkp_val = 1'b0;
    bus1.lkp_val = 1'b0;
    #1;
    chk("midrst_rsp", {bus0.rsp_val, bus1.rsp_val}, 2'b00);
    chk("midrst_busy", {busy0, busy1}, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
